// File: rtl/stream_framer.sv
// Re-frames an AXI-Stream video-like flow: regenerates tuser/tlast from beat counters,
// drops pre-frame junk, flags marker disagreements and pads out frames whose source stalls.
module stream_framer #(
    parameter int                          AXIS_TDATA_WIDTH = 32,
    parameter int                          MAX_DIM_W        = 12,
    parameter int                          TIMEOUT_CYCLES   = 1024,
    parameter logic [AXIS_TDATA_WIDTH-1:0] PAD_VALUE        = '0
) (
    input  logic                        aclk,
    input  logic                        aresetn,
    input  logic [MAX_DIM_W-1:0]        cfg_width,
    input  logic [MAX_DIM_W-1:0]        cfg_height,
    input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
    input  logic                        s_axis_tvalid,
    output logic                        s_axis_tready,
    input  logic                        s_axis_tlast,
    input  logic                        s_axis_tuser,
    output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
    output logic                        m_axis_tvalid,
    input  logic                        m_axis_tready,
    output logic                        m_axis_tlast,
    output logic                        m_axis_tuser,
    output logic                        frame_err,
    output logic                        line_err,
    output logic                        timeout_err,
    output logic [15:0]                 drop_cnt
);

    localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [MAX_DIM_W-1:0] DIM_ONE    = MAX_DIM_W'(1);
    localparam logic [IDLE_W-1:0]    IDLE_ONE   = IDLE_W'(1);
    localparam logic [IDLE_W-1:0]    TIMEOUT_M1 = IDLE_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_PAD    = 2'd2
    } state_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    state_t                  state_q, state_d;
    logic [MAX_DIM_W-1:0]    w_q, h_q, col_q, row_q;
    logic [IDLE_W-1:0]       idle_q;
    logic [15:0]             drop_q;

    logic                        vld_p1, tlast_p1, tuser_p1;
    logic [AXIS_TDATA_WIDTH-1:0] tdata_p1;

    logic                    out_free, in_ready, accept, sof, cfg_ok, start;
    logic                    data_beat, pad_beat, emit, drop, early_sof;
    logic                    line_mis, idle_tick, timeout_hit, at_eol, at_eof;
    logic [MAX_DIM_W-1:0]    eff_w, eff_h, eff_col, eff_row;

    assign out_free = m_axis_tready || !vld_p1;

    // State register
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Output / control decode. A start-of-frame beat is evaluated against the
    // freshly presented config at position (0,0), so 1-wide or 1x1 frames close on it.
    always_comb begin
        in_ready    = out_free && (state_q != S_PAD);
        accept      = s_axis_tvalid && in_ready;
        sof         = accept && s_axis_tuser;
        cfg_ok      = (cfg_width != '0) && (cfg_height != '0);
        start       = sof && cfg_ok && (state_q != S_PAD);
        data_beat   = accept && !s_axis_tuser && (state_q == S_ACTIVE);
        pad_beat    = (state_q == S_PAD) && out_free;
        emit        = start || data_beat || pad_beat;
        drop        = accept && !start && !data_beat;
        early_sof   = sof && (state_q == S_ACTIVE);

        eff_w       = start ? cfg_width  : w_q;
        eff_h       = start ? cfg_height : h_q;
        eff_col     = start ? '0 : col_q;
        eff_row     = start ? '0 : row_q;
        at_eol      = (eff_col == eff_w - DIM_ONE);
        at_eof      = at_eol && (eff_row == eff_h - DIM_ONE);

        line_mis    = (start || data_beat) && (s_axis_tlast != at_eol);
        // Only starved cycles count; a downstream stall drops in_ready and freezes the count.
        idle_tick   = (state_q == S_ACTIVE) && in_ready && !s_axis_tvalid;
        timeout_hit = idle_tick && (idle_q == TIMEOUT_M1);
    end

    assign s_axis_tready = in_ready;

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = at_eof ? S_IDLE : S_ACTIVE;
                end
            end
            S_ACTIVE: begin
                if (start) begin
                    state_d = at_eof ? S_IDLE : S_ACTIVE;
                end else if (sof) begin
                    // restart request with an unusable config abandons the frame
                    state_d = S_IDLE;
                end else if (data_beat && at_eof) begin
                    state_d = S_IDLE;
                end else if (timeout_hit) begin
                    state_d = S_PAD;
                end
            end
            S_PAD: begin
                if (pad_beat && at_eof) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Frame geometry, position and idle tracking
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            w_q    <= '0;
            h_q    <= '0;
            col_q  <= '0;
            row_q  <= '0;
            idle_q <= '0;
            drop_q <= '0;
        end else begin
            if (start) begin
                w_q <= cfg_width;
                h_q <= cfg_height;
            end
            if (emit) begin
                if (at_eol) begin
                    col_q <= '0;
                    row_q <= eff_row + DIM_ONE;
                end else begin
                    col_q <= eff_col + DIM_ONE;
                    row_q <= eff_row;
                end
            end
            if (accept || (state_q != S_ACTIVE) || timeout_hit) begin
                idle_q <= '0;
            end else if (idle_tick) begin
                idle_q <= idle_q + IDLE_ONE;
            end
            if (drop) begin
                drop_q <= sat_inc16(drop_q);
            end
        end
    end

    // Output register stage
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            vld_p1      <= 1'b0;
            tdata_p1    <= '0;
            tlast_p1    <= 1'b0;
            tuser_p1    <= 1'b0;
            frame_err   <= 1'b0;
            line_err    <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            if (emit) begin
                vld_p1   <= 1'b1;
                tdata_p1 <= pad_beat ? PAD_VALUE : s_axis_tdata;
                tlast_p1 <= at_eol;
                tuser_p1 <= start;
            end else if (m_axis_tready) begin
                vld_p1   <= 1'b0;
            end
            frame_err   <= early_sof;
            line_err    <= line_mis;
            timeout_err <= timeout_hit;
        end
    end

    assign m_axis_tvalid = vld_p1;
    assign m_axis_tdata  = tdata_p1;
    assign m_axis_tlast  = tlast_p1;
    assign m_axis_tuser  = tuser_p1;
    assign drop_cnt      = drop_q;

endmodule

// File: tb/tb_stream_framer.sv
// Self-checking bench for stream_framer: vector table plus hand-written corner sequences,
// with an output scoreboard fed at drive time and drained by a monitor.
module tb_stream_framer;

    localparam int          DW   = 32;
    localparam int          DIMW = 12;
    localparam logic [31:0] PADV = 32'hDEAD_BEEF;

    logic            aclk = 1'b0;
    logic            aresetn;
    logic [DIMW-1:0] cfg_width, cfg_height;
    logic [DW-1:0]   s_axis_tdata;
    logic            s_axis_tvalid, s_axis_tready, s_axis_tlast, s_axis_tuser;
    logic [DW-1:0]   m_axis_tdata;
    logic            m_axis_tvalid, m_axis_tready, m_axis_tlast, m_axis_tuser;
    logic            frame_err, line_err, timeout_err;
    logic [15:0]     drop_cnt;

    always #5 aclk = ~aclk;

    stream_framer #(
        .AXIS_TDATA_WIDTH(DW),
        .MAX_DIM_W       (DIMW),
        .TIMEOUT_CYCLES  (8),
        .PAD_VALUE       (PADV)
    ) dut (
        .aclk         (aclk),
        .aresetn      (aresetn),
        .cfg_width    (cfg_width),
        .cfg_height   (cfg_height),
        .s_axis_tdata (s_axis_tdata),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready),
        .s_axis_tlast (s_axis_tlast),
        .s_axis_tuser (s_axis_tuser),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .m_axis_tlast (m_axis_tlast),
        .m_axis_tuser (m_axis_tuser),
        .frame_err    (frame_err),
        .line_err     (line_err),
        .timeout_err  (timeout_err),
        .drop_cnt     (drop_cnt)
    );

    typedef struct packed {
        logic [31:0] d;
        logic        l;
        logic        u;
    } exp_t;

    typedef struct {
        logic [31:0] d;
        logic        u_in;
        logic        l_in;
        logic        u_exp;
        logic        l_exp;
    } vec_t;

    exp_t q[$];
    vec_t vt[8];

    int   n_checks = 0;
    int   n_pass   = 0;
    int   fe_cnt   = 0;
    int   le_cnt   = 0;
    int   to_cnt   = 0;
    bit   rnd_mode = 1'b0;
    bit   stall_prev = 1'b0;
    exp_t held;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Downstream ready: changes 1 time unit after each rising edge
    always @(posedge aclk) begin
        #1;
        m_axis_tready = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Output monitor on the falling edge
    always @(negedge aclk) begin
        exp_t e;
        if (!aresetn) begin
            stall_prev = 1'b0;
        end else begin
            if (frame_err)   fe_cnt++;
            if (line_err)    le_cnt++;
            if (timeout_err) to_cnt++;
            if (stall_prev) begin
                chk("stall_valid", 64'(m_axis_tvalid), 64'd1);
                chk("stall_hold", 64'({m_axis_tdata, m_axis_tlast, m_axis_tuser}), 64'(held));
            end
            if (m_axis_tvalid && m_axis_tready) begin
                if (q.size() == 0) begin
                    chk("unexpected_beat", 64'(q.size()), 64'd1);
                end else begin
                    e = q.pop_front();
                    chk("beat", 64'({m_axis_tdata, m_axis_tlast, m_axis_tuser}), 64'(e));
                end
            end
            stall_prev = m_axis_tvalid && !m_axis_tready;
            held       = {m_axis_tdata, m_axis_tlast, m_axis_tuser};
        end
    end

    // All driver tasks start and end 2 time units after a rising edge
    task automatic send(input logic [31:0] d, input logic u, input logic l);
        int n;
        bit hs;
        n = 0;
        s_axis_tdata  = d;
        s_axis_tuser  = u;
        s_axis_tlast  = l;
        s_axis_tvalid = 1'b1;
        do begin
            hs = s_axis_tready;
            @(posedge aclk);
            #2;
            n++;
        end while (!hs && n < 200);
        chk("send_accept", 64'(hs), 64'd1);
        s_axis_tvalid = 1'b0;
    endtask

    task automatic send_exp(input logic [31:0] d, input logic u, input logic l,
                            input logic eu, input logic el);
        exp_t e;
        e = '{d: d, l: el, u: eu};
        q.push_back(e);
        send(d, u, l);
    endtask

    task automatic gap(input int n);
        repeat (n) begin
            @(posedge aclk);
            #2;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 300) begin
            @(posedge aclk);
            #2;
            n++;
        end
        chk("drain_empty", 64'(q.size()), 64'd0);
        gap(1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int fe0, le0, to0, d0, n;
        exp_t pe;

        vt = '{
            '{32'hA000_0000, 1'b1, 1'b0, 1'b1, 1'b0},
            '{32'hA000_0001, 1'b0, 1'b0, 1'b0, 1'b0},
            '{32'hA000_0002, 1'b0, 1'b0, 1'b0, 1'b0},
            '{32'hA000_0003, 1'b0, 1'b1, 1'b0, 1'b1},
            '{32'hA000_0004, 1'b0, 1'b0, 1'b0, 1'b0},
            '{32'hA000_0005, 1'b0, 1'b0, 1'b0, 1'b0},
            '{32'hA000_0006, 1'b0, 1'b0, 1'b0, 1'b0},
            '{32'hA000_0007, 1'b0, 1'b1, 1'b0, 1'b1}
        };

        aresetn       = 1'b0;
        cfg_width     = 12'd4;
        cfg_height    = 12'd2;
        s_axis_tdata  = '0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        s_axis_tuser  = 1'b0;
        m_axis_tready = 1'b1;

        repeat (2) @(posedge aclk);
        #2;
        chk("rst_mvalid", 64'(m_axis_tvalid), 64'd0);
        chk("rst_mdata", 64'(m_axis_tdata), 64'd0);
        chk("rst_marks", 64'({m_axis_tlast, m_axis_tuser}), 64'd0);
        chk("rst_errs", 64'({frame_err, line_err, timeout_err}), 64'd0);
        chk("rst_drop", 64'(drop_cnt), 64'd0);
        aresetn = 1'b1;
        gap(1);

        // Junk before the first start-of-frame is dropped
        for (int i = 0; i < 3; i++) send(32'h0000_0100 + i, 1'b0, 1'b0);
        chk("drop_cnt_3", 64'(drop_cnt), 64'd3);

        // Basic 4x2 frame from the vector table
        fe0 = fe_cnt; le0 = le_cnt; to0 = to_cnt;
        for (int i = 0; i < 8; i++) begin
            send_exp(vt[i].d, vt[i].u_in, vt[i].l_in, vt[i].u_exp, vt[i].l_exp);
            if (i == 0) begin
                chk("latency_valid", 64'(m_axis_tvalid), 64'd1);
                chk("latency_data", 64'(m_axis_tdata), 64'(vt[0].d));
            end
        end
        drain();
        chk("basic_no_errs", 64'((fe_cnt - fe0) + (le_cnt - le0) + (to_cnt - to0)), 64'd0);

        // Early start-of-frame on the 6th beat restarts the frame
        fe0 = fe_cnt; le0 = le_cnt;
        for (int i = 0; i < 13; i++) begin
            send_exp(32'hE000_0000 + i, (i == 0 || i == 5), (i == 3 || i == 8 || i == 12),
                     (i == 0 || i == 5), (i == 3 || i == 8 || i == 12));
        end
        drain();
        chk("early_sof_frame_err", 64'(fe_cnt - fe0), 64'd1);
        chk("early_sof_no_line_err", 64'(le_cnt - le0), 64'd0);

        // Zero config drops a start-of-frame beat
        cfg_width = 12'd0;
        d0 = drop_cnt;
        send(32'hBAD0_0000, 1'b1, 1'b0);
        chk("zero_cfg_drop", 64'(drop_cnt), 64'(d0 + 1));

        // Degenerate shapes, then wrong input tlast on a 2x1 frame
        le0 = le_cnt;
        cfg_width = 12'd1; cfg_height = 12'd1;
        send_exp(32'hA1A1_0000, 1'b1, 1'b1, 1'b1, 1'b1);
        cfg_width = 12'd1; cfg_height = 12'd3;
        send_exp(32'hB0B0_0000, 1'b1, 1'b1, 1'b1, 1'b1);
        send_exp(32'hB0B0_0001, 1'b0, 1'b1, 1'b0, 1'b1);
        send_exp(32'hB0B0_0002, 1'b0, 1'b1, 1'b0, 1'b1);
        cfg_width = 12'd2; cfg_height = 12'd1;
        send_exp(32'hC0C0_0000, 1'b1, 1'b1, 1'b1, 1'b0);
        send_exp(32'hC0C0_0001, 1'b0, 1'b0, 1'b0, 1'b1);
        drain();
        chk("line_err_count", 64'(le_cnt - le0), 64'd2);

        // Source stalls after 5 of 8 beats: timeout then padding
        cfg_width = 12'd4; cfg_height = 12'd2;
        to0 = to_cnt;
        for (int i = 0; i < 5; i++) send_exp(32'hF000_0000 + i, (i == 0), (i == 3), (i == 0), (i == 3));
        for (int i = 0; i < 3; i++) begin
            pe = '{d: PADV, l: (i == 2), u: 1'b0};
            q.push_back(pe);
        end
        n = 0;
        do begin
            @(posedge aclk);
            #2;
            n++;
        end while (!timeout_err && n < 40);
        chk("timeout_latency", 64'(n), 64'd8);
        chk("pad_tready_0", 64'(s_axis_tready), 64'd0);
        for (int k = 1; k < 3; k++) begin
            gap(1);
            chk("pad_tready_low", 64'(s_axis_tready), 64'd0);
        end
        gap(1);
        chk("pad_done_tready", 64'(s_axis_tready), 64'd1);
        drain();
        chk("timeout_pulse", 64'(to_cnt - to0), 64'd1);

        // Random downstream backpressure over 3 frames
        rnd_mode = 1'b1;
        cfg_width = 12'd3; cfg_height = 12'd2;
        fe0 = fe_cnt; le0 = le_cnt; to0 = to_cnt;
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < 6; i++) begin
                send_exp($urandom, (i == 0), (i % 3 == 2), (i == 0), (i % 3 == 2));
                gap($urandom_range(0, 2));
            end
        end
        drain();
        rnd_mode = 1'b0;
        chk("rand_no_timeout", 64'(to_cnt - to0), 64'd0);
        chk("rand_no_errs", 64'((fe_cnt - fe0) + (le_cnt - le0)), 64'd0);

        // Reset in the middle of a frame
        cfg_width = 12'd4; cfg_height = 12'd2;
        for (int i = 0; i < 3; i++) send_exp(32'h7000_0000 + i, (i == 0), 1'b0, (i == 0), 1'b0);
        drain();
        aresetn = 1'b0;
        #1;
        chk("midrst_outs", 64'({m_axis_tvalid, m_axis_tlast, m_axis_tuser, m_axis_tdata}), 64'd0);
        chk("midrst_flags", 64'({frame_err, line_err, timeout_err, drop_cnt}), 64'd0);
        @(posedge aclk);
        #2;
        gap(1);
        aresetn = 1'b1;
        for (int k = 0; k < 4; k++) begin
            gap(1);
            chk("post_rst_quiet", 64'(m_axis_tvalid), 64'd0);
        end
        fe0 = fe_cnt; le0 = le_cnt; to0 = to_cnt;
        for (int i = 0; i < 8; i++) send_exp(vt[i].d, vt[i].u_in, vt[i].l_in, vt[i].u_exp, vt[i].l_exp);
        drain();
        chk("post_rst_no_errs", 64'((fe_cnt - fe0) + (le_cnt - le0) + (to_cnt - to0)), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/stream_framer.md
STREAM_FRAMER -- requirements
Module: stream_framer

Interface
REQ-001 SHALL have parameter AXIS_TDATA_WIDTH, default 32, meaning stream data width in bits.
REQ-002 SHALL have parameter MAX_DIM_W, default 12, meaning width of the line-length and line-count config ports.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1024, meaning idle cycles mid-frame before pad-out; must be at least 2.
REQ-004 SHALL have parameter PAD_VALUE, default 0, meaning the tdata value used for padded beats.
REQ-005 SHALL run on one clock, and reset SHALL be asynchronous and active-low.
REQ-006 SHALL have the port: aclk  in  1  clock.
REQ-007 SHALL have the port: aresetn  in  1  asynchronous active-low reset.
REQ-008 SHALL have the port: cfg_width  in  MAX_DIM_W  beats per line.
REQ-009 SHALL have the port: cfg_height  in  MAX_DIM_W  lines per frame.
REQ-010 SHALL have the ports: s_axis_tdata/tvalid/tready/tlast/tuser  in/in/out/in/in  AXIS_TDATA_WIDTH/1/1/1/1  upstream stream.
REQ-011 SHALL have the ports: m_axis_tdata/tvalid/tready/tlast/tuser  out/out/in/out/out  AXIS_TDATA_WIDTH/1/1/1/1  regenerated stream.
REQ-012 SHALL have the port: frame_err  out  1  pulse on early start-of-frame.
REQ-013 SHALL have the port: line_err  out  1  pulse when input tlast disagrees with the line position.
REQ-014 SHALL have the port: timeout_err  out  1  pulse on pad-out entry.
REQ-015 SHALL have the port: drop_cnt  out  16  saturating count of dropped beats.

Function
REQ-016 SHALL regenerate output tlast and tuser from beat counters, not from the input markers; input tlast is checked only.
REQ-017 SHALL register the output: accepted input beat appears on m_axis one cycle later.
REQ-018 SHALL drive s_axis_tready = (m_axis_tready or not m_axis_tvalid) in IDLE and ACTIVE, and 0 in PAD.
REQ-019 SHALL hold m_axis_tdata/tlast/tuser stable while m_axis_tvalid=1 and m_axis_tready=0.
REQ-020 SHALL implement the FSM states IDLE, ACTIVE and PAD.
REQ-021 In IDLE, accepted beats with tuser=0 SHALL be dropped (not output), and drop_cnt SHALL increment, saturating at 0xFFFF.
REQ-022 In IDLE, on an accepted beat with tuser=1: latch cfg_width/cfg_height, output the beat with tuser=1, set col=1, row=0, go to ACTIVE.
REQ-023 If latched width or height is 0, beats with tuser=1 SHALL be dropped like any other, and the FSM SHALL stay in IDLE.
REQ-024 In ACTIVE, each accepted beat SHALL be output with tuser=0 and col SHALL increment.
REQ-025 For the beat at col=width-1, tlast SHALL be output as 1, col SHALL go to 0, and row SHALL increment.
REQ-026 For the beat at col=width-1 and row=height-1 (end of frame), the FSM SHALL go to IDLE.
REQ-027 With width=1, every beat SHALL carry tlast; with width=height=1, the single beat SHALL carry both tuser and tlast.
REQ-028 An accepted input tuser=1 in ACTIVE (early start-of-frame) SHALL pulse frame_err for 1 cycle, relatch the config, and treat the beat as the first beat of a new frame (output tuser=1, col=1, row=0); the old frame SHALL not be padded.
REQ-029 An accepted beat whose input tlast differs from (col==width-1) SHALL pulse line_err for 1 cycle; output markers SHALL be unaffected.
REQ-030 The idle counter SHALL clear on each accepted beat and in IDLE, and SHALL increment otherwise in ACTIVE.
REQ-031 When the idle counter reaches TIMEOUT_CYCLES, the FSM SHALL pulse timeout_err and go to PAD.
REQ-032 In PAD, the block SHALL emit PAD_VALUE beats with correct tlast whenever the output register is free, until the end-of-frame beat, then go to IDLE.
REQ-033 Downstream stall SHALL never advance any counter or the idle counter's timeout decision; timeout SHALL count only cycles with s_axis_tready=1 and s_axis_tvalid=0.
REQ-034 Counter widths SHALL be MAX_DIM_W bits, with no wrap inside a frame because the compare occurs before the increment.

Reset
REQ-035 On aresetn=0, immediately (asynchronously): FSM=IDLE; m_axis_tvalid/tlast/tuser=0; m_axis_tdata=0; frame_err/line_err/timeout_err=0; drop_cnt=0; col/row/idle counter=0.
REQ-036 A reset mid-frame SHALL abandon the frame with no padding; after release, the first output SHALL be the next start-of-frame beat.

Verification
REQ-037 Verify: width=4, height=2, 8 beats D0..D7, input tuser on D0, tlast on D3,D7, m_axis_tready=1 -> output D0..D7 one cycle delayed, tuser on D0 only, tlast on D3,D7, no error pulses.
REQ-038 Verify: 3 beats with tuser=0 then start-of-frame -> drop_cnt=3, first output beat carries tuser=1.
REQ-039 Verify: width=4, height=2, tuser asserted again on the 6th beat -> frame_err 1-cycle pulse; the 6th beat is output with tuser=1, and tlast follows 3 beats later.
REQ-040 Verify: TIMEOUT_CYCLES=8, upstream stops after 5 of 8 beats -> timeout_err pulse after 8 idle cycles, 3 PAD_VALUE beats, tlast on the last, s_axis_tready=0 throughout PAD.
REQ-041 Verify: random m_axis_tready (50%) over 3 frames -> no beat lost or duplicated, output held stable during stall, no timeout from downstream stall alone.
REQ-042 Verify: aresetn pulsed low after beat 3 of a frame -> all outputs 0 during reset, no padding, and the next frame is output correctly.
